// File: rtl/mem_arbiter.sv
// Arbiter sharing the single pmem line port between the I-cache and the D-cache.
// One line transaction is in flight at a time; the request is latched at grant and held to pmem_resp.
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned LINE_WIDTH     = 128,
    parameter bit          FIXED_PRIORITY = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  icache_read,
    input  logic [ADDR_WIDTH-1:0] icache_addr,
    output logic [LINE_WIDTH-1:0] icache_rdata,
    output logic                  icache_resp,

    input  logic                  dcache_read,
    input  logic                  dcache_write,
    input  logic [ADDR_WIDTH-1:0] dcache_addr,
    input  logic [LINE_WIDTH-1:0] dcache_wdata,
    output logic [LINE_WIDTH-1:0] dcache_rdata,
    output logic                  dcache_resp,

    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_addr,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    typedef enum logic [1:0] {
        StIdle,
        StServeI,
        StServeD
    } state_e;

    typedef enum logic {
        SrcICache,
        SrcDCache
    } src_e;

    state_e                state_q, state_d;
    src_e                  last_served_q, last_served_d;
    logic                  op_write_q, op_write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_WIDTH-1:0] wdata_q, wdata_d;

    logic i_req;
    logic d_req;
    logic d_wins;

    assign i_req = icache_read;
    assign d_req = dcache_read | dcache_write;

    // D takes the port when alone, under fixed priority, or when I was served last.
    assign d_wins = d_req & (~i_req | FIXED_PRIORITY | (last_served_q == SrcICache));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            last_served_q <= SrcICache;
            op_write_q    <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
        end else begin
            state_q       <= state_d;
            last_served_q <= last_served_d;
            op_write_q    <= op_write_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        last_served_d = last_served_q;
        op_write_d    = op_write_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;

        unique case (state_q)
            StIdle: begin
                if (d_wins) begin
                    state_d       = StServeD;
                    last_served_d = SrcDCache;
                    addr_d        = dcache_addr;
                    // Read and write together is a writeback.
                    op_write_d    = dcache_write;
                    if (dcache_write) begin
                        wdata_d = dcache_wdata;
                    end
                end else if (i_req) begin
                    state_d       = StServeI;
                    last_served_d = SrcICache;
                    addr_d        = icache_addr;
                    op_write_d    = 1'b0;
                end
            end
            StServeI, StServeD: begin
                if (pmem_resp) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign pmem_read  = (state_q == StServeI) | ((state_q == StServeD) & ~op_write_q);
    assign pmem_write = (state_q == StServeD) & op_write_q;
    assign pmem_addr  = addr_q;
    assign pmem_wdata = wdata_q;

    assign icache_resp  = (state_q == StServeI) & pmem_resp;
    assign dcache_resp  = (state_q == StServeD) & pmem_resp;
    assign icache_rdata = pmem_rdata;
    assign dcache_rdata = pmem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, multi-cycle corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_mem_arbiter;

    logic         clk;
    logic         reset;

    logic         icache_read;
    logic [15:0]  icache_addr;
    logic [127:0] icache_rdata;
    logic         icache_resp;
    logic         dcache_read;
    logic         dcache_write;
    logic [15:0]  dcache_addr;
    logic [127:0] dcache_wdata;
    logic [127:0] dcache_rdata;
    logic         dcache_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_addr;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    logic         f_icache_read;
    logic [15:0]  f_icache_addr;
    logic [127:0] f_icache_rdata;
    logic         f_icache_resp;
    logic         f_dcache_read;
    logic         f_dcache_write;
    logic [15:0]  f_dcache_addr;
    logic [127:0] f_dcache_wdata;
    logic [127:0] f_dcache_rdata;
    logic         f_dcache_resp;
    logic         f_pmem_read;
    logic         f_pmem_write;
    logic [15:0]  f_pmem_addr;
    logic [127:0] f_pmem_wdata;
    logic [127:0] f_pmem_rdata;
    logic         f_pmem_resp;

    int n_checks = 0;
    int n_errors = 0;

    mem_arbiter #(
        .ADDR_WIDTH    (16),
        .LINE_WIDTH    (128),
        .FIXED_PRIORITY(1'b0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .icache_read (icache_read),
        .icache_addr (icache_addr),
        .icache_rdata(icache_rdata),
        .icache_resp (icache_resp),
        .dcache_read (dcache_read),
        .dcache_write(dcache_write),
        .dcache_addr (dcache_addr),
        .dcache_wdata(dcache_wdata),
        .dcache_rdata(dcache_rdata),
        .dcache_resp (dcache_resp),
        .pmem_read   (pmem_read),
        .pmem_write  (pmem_write),
        .pmem_addr   (pmem_addr),
        .pmem_wdata  (pmem_wdata),
        .pmem_rdata  (pmem_rdata),
        .pmem_resp   (pmem_resp)
    );

    mem_arbiter #(
        .ADDR_WIDTH    (16),
        .LINE_WIDTH    (128),
        .FIXED_PRIORITY(1'b1)
    ) dut_fp (
        .clk         (clk),
        .reset       (reset),
        .icache_read (f_icache_read),
        .icache_addr (f_icache_addr),
        .icache_rdata(f_icache_rdata),
        .icache_resp (f_icache_resp),
        .dcache_read (f_dcache_read),
        .dcache_write(f_dcache_write),
        .dcache_addr (f_dcache_addr),
        .dcache_wdata(f_dcache_wdata),
        .dcache_rdata(f_dcache_rdata),
        .dcache_resp (f_dcache_resp),
        .pmem_read   (f_pmem_read),
        .pmem_write  (f_pmem_write),
        .pmem_addr   (f_pmem_addr),
        .pmem_wdata  (f_pmem_wdata),
        .pmem_rdata  (f_pmem_rdata),
        .pmem_resp   (f_pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic         iread;
        logic         dread;
        logic         dwrite;
        logic [15:0]  iaddr;
        logic [15:0]  daddr;
        logic [127:0] wdata;
        logic         presp;
        logic [127:0] prdata;
        logic         e_pr;
        logic         e_pw;
        logic [15:0]  e_addr;
        logic [127:0] e_wdata;
        logic         e_iresp;
        logic         e_dresp;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic vec_t mk(input logic ir, input logic dr, input logic dw,
                                input logic [15:0] ia, input logic [15:0] da,
                                input logic [127:0] wd, input logic pr_in,
                                input logic [127:0] rd, input logic epr, input logic epw,
                                input logic [15:0] ea, input logic [127:0] ewd,
                                input logic eir, input logic edr);
        vec_t v;
        v.iread = ir;    v.dread = dr;    v.dwrite = dw;
        v.iaddr = ia;    v.daddr = da;    v.wdata = wd;
        v.presp = pr_in; v.prdata = rd;
        v.e_pr = epr;    v.e_pw = epw;    v.e_addr = ea;
        v.e_wdata = ewd; v.e_iresp = eir; v.e_dresp = edr;
        return v;
    endfunction

    task automatic clear_inputs();
        icache_read  = 1'b0;
        icache_addr  = '0;
        dcache_read  = 1'b0;
        dcache_write = 1'b0;
        dcache_addr  = '0;
        dcache_wdata = '0;
        pmem_rdata   = '0;
        pmem_resp    = 1'b0;
        f_icache_read  = 1'b0;
        f_icache_addr  = '0;
        f_dcache_read  = 1'b0;
        f_dcache_write = 1'b0;
        f_dcache_addr  = '0;
        f_dcache_wdata = '0;
        f_pmem_rdata   = '0;
        f_pmem_resp    = 1'b0;
    endtask

    // Ends at a negedge with reset released and all inputs idle.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        clear_inputs();
        @(negedge clk);
        reset = 1'b0;
    endtask

    localparam logic [127:0] LA5 = {16{8'hA5}};
    localparam logic [127:0] LW1 = {4{32'hDEADBEEF}};
    localparam logic [127:0] LW2 = {4{32'h01234567}};
    localparam logic [127:0] LW3 = {4{32'hCAFEF00D}};
    localparam logic [127:0] LP1 = {4{32'h5A5A0F0F}};

    // Reference model state (transaction level).
    int           m_owner;   // 0 = none, 1 = I-cache, 2 = D-cache
    bit           m_last_d;
    bit           m_wr;
    logic [15:0]  m_addr;
    logic [127:0] m_wdata;

    initial begin
        logic         e_pr, e_pw, e_ir, e_dr;
        bit           prev_i, prev_d;
        int unsigned  op;
        logic [127:0] rd;

        reset = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        #1;
        chk("reset_pmem_read", 128'(pmem_read), 128'(0));
        chk("reset_pmem_write", 128'(pmem_write), 128'(0));
        chk("reset_pmem_addr", 128'(pmem_addr), 128'(0));
        chk("reset_pmem_wdata", pmem_wdata, 128'(0));
        chk("reset_resps", 128'({icache_resp, dcache_resp}), 128'(0));
        @(negedge clk);
        reset = 1'b0;

        // ---------------- directed vector table ----------------
        vecs[0]  = mk(1,0,0,16'h1230,0,0,0,0,          0,0,16'h0000,0,  0,0);
        vecs[1]  = mk(1,0,0,16'h1230,0,0,0,0,          1,0,16'h1230,0,  0,0);
        vecs[2]  = mk(1,0,0,16'h1230,0,0,1,LA5,        1,0,16'h1230,0,  1,0);
        vecs[3]  = mk(0,0,0,0,0,0,0,0,                 0,0,16'h1230,0,  0,0);
        vecs[4]  = mk(0,0,0,0,0,0,1,LP1,               0,0,16'h1230,0,  0,0);
        vecs[5]  = mk(0,0,1,0,16'h4000,LW1,0,0,        0,0,16'h1230,0,  0,0);
        vecs[6]  = mk(0,0,1,0,16'h4000,LW2,0,0,        0,1,16'h4000,LW1,0,0);
        vecs[7]  = mk(0,0,1,0,16'h4000,LW2,1,LP1,      0,1,16'h4000,LW1,0,1);
        vecs[8]  = mk(0,0,0,0,0,0,0,0,                 0,0,16'h4000,LW1,0,0);
        vecs[9]  = mk(0,1,1,0,16'h5550,LW3,0,0,        0,0,16'h4000,LW1,0,0);
        vecs[10] = mk(0,1,1,0,16'h5550,LW3,0,0,        0,1,16'h5550,LW3,0,0);
        vecs[11] = mk(0,1,1,0,16'h5550,LW3,1,LA5,      0,1,16'h5550,LW3,0,1);
        vecs[12] = mk(0,0,0,0,0,0,0,0,                 0,0,16'h5550,LW3,0,0);
        vecs[13] = mk(0,1,0,0,16'h6660,LW2,0,0,        0,0,16'h5550,LW3,0,0);
        vecs[14] = mk(0,1,0,0,16'h6660,LW2,0,0,        1,0,16'h6660,LW3,0,0);
        vecs[15] = mk(0,1,0,0,16'h6660,LW2,1,LP1,      1,0,16'h6660,LW3,0,1);
        vecs[16] = mk(0,0,0,0,0,0,0,0,                 0,0,16'h6660,LW3,0,0);

        for (int i = 0; i < 17; i++) begin
            icache_read  = vecs[i].iread;
            icache_addr  = vecs[i].iaddr;
            dcache_read  = vecs[i].dread;
            dcache_write = vecs[i].dwrite;
            dcache_addr  = vecs[i].daddr;
            dcache_wdata = vecs[i].wdata;
            pmem_resp    = vecs[i].presp;
            pmem_rdata   = vecs[i].prdata;
            #1;
            chk($sformatf("vec%0d_pmem_read", i), 128'(pmem_read), 128'(vecs[i].e_pr));
            chk($sformatf("vec%0d_pmem_write", i), 128'(pmem_write), 128'(vecs[i].e_pw));
            chk($sformatf("vec%0d_pmem_addr", i), 128'(pmem_addr), 128'(vecs[i].e_addr));
            chk($sformatf("vec%0d_pmem_wdata", i), pmem_wdata, vecs[i].e_wdata);
            chk($sformatf("vec%0d_icache_resp", i), 128'(icache_resp), 128'(vecs[i].e_iresp));
            chk($sformatf("vec%0d_dcache_resp", i), 128'(dcache_resp), 128'(vecs[i].e_dresp));
            chk($sformatf("vec%0d_icache_rdata", i), icache_rdata, vecs[i].prdata);
            chk($sformatf("vec%0d_dcache_rdata", i), dcache_rdata, vecs[i].prdata);
            @(negedge clk);
        end

        // ---------------- round-robin alternation, both continuously requesting ----------------
        do_reset();
        icache_read = 1'b1;
        icache_addr = 16'h1000;
        dcache_read = 1'b1;
        dcache_addr = 16'h2000;
        for (int t = 0; t < 6; t++) begin
            #1;
            chk($sformatf("rr%0d_bubble", t), 128'({pmem_read, pmem_write}), 128'(0));
            @(negedge clk);
            rd = rand128();
            pmem_resp  = 1'b1;
            pmem_rdata = rd;
            #1;
            chk($sformatf("rr%0d_strobe", t), 128'(pmem_read), 128'(1));
            chk($sformatf("rr%0d_addr", t), 128'(pmem_addr),
                128'((t % 2 == 0) ? 16'h2000 : 16'h1000));
            chk($sformatf("rr%0d_iresp", t), 128'(icache_resp), 128'((t % 2) == 1));
            chk($sformatf("rr%0d_dresp", t), 128'(dcache_resp), 128'((t % 2) == 0));
            @(negedge clk);
            pmem_resp = 1'b0;
        end
        icache_read = 1'b0;
        dcache_read = 1'b0;

        // ---------------- fixed priority: D starves I until D drops ----------------
        f_icache_read  = 1'b1;
        f_icache_addr  = 16'h3330;
        f_dcache_write = 1'b1;
        f_dcache_addr  = 16'h4440;
        f_dcache_wdata = LW2;
        for (int t = 0; t < 4; t++) begin
            #1;
            chk($sformatf("fp%0d_bubble", t), 128'({f_pmem_read, f_pmem_write}), 128'(0));
            @(negedge clk);
            f_pmem_resp  = 1'b1;
            f_pmem_rdata = LP1;
            #1;
            if (t < 3) begin
                chk($sformatf("fp%0d_write", t), 128'(f_pmem_write), 128'(1));
                chk($sformatf("fp%0d_addr", t), 128'(f_pmem_addr), 128'(16'h4440));
                chk($sformatf("fp%0d_dresp", t), 128'(f_dcache_resp), 128'(1));
                chk($sformatf("fp%0d_iresp", t), 128'(f_icache_resp), 128'(0));
            end else begin
                chk("fp_i_read", 128'(f_pmem_read), 128'(1));
                chk("fp_i_addr", 128'(f_pmem_addr), 128'(16'h3330));
                chk("fp_i_iresp", 128'(f_icache_resp), 128'(1));
                chk("fp_i_rdata", f_icache_rdata, LP1);
            end
            @(negedge clk);
            f_pmem_resp = 1'b0;
            if (t == 2) f_dcache_write = 1'b0;
            if (t == 3) f_icache_read = 1'b0;
        end

        // ---------------- reset in the middle of a D transaction ----------------
        do_reset();
        dcache_read = 1'b1;
        dcache_addr = 16'h7770;
        @(negedge clk);
        #1;
        chk("rst_mid_serving", 128'(pmem_read), 128'(1));
        reset = 1'b1;
        #1;
        chk("rst_mid_strobes", 128'({pmem_read, pmem_write}), 128'(0));
        chk("rst_mid_addr", 128'(pmem_addr), 128'(0));
        @(negedge clk);
        reset       = 1'b0;
        dcache_read = 1'b0;
        pmem_resp   = 1'b1;
        pmem_rdata  = LA5;
        #1;
        chk("rst_mid_no_dresp", 128'(dcache_resp), 128'(0));
        chk("rst_mid_no_iresp", 128'(icache_resp), 128'(0));
        @(negedge clk);
        pmem_resp   = 1'b0;
        dcache_read = 1'b1;
        dcache_addr = 16'h7780;
        #1;
        chk("rst_mid_idle", 128'({pmem_read, pmem_write}), 128'(0));
        @(negedge clk);
        pmem_resp = 1'b1;
        #1;
        chk("rst_after_grant", 128'(pmem_read), 128'(1));
        chk("rst_after_addr", 128'(pmem_addr), 128'(16'h7780));
        chk("rst_after_dresp", 128'(dcache_resp), 128'(1));
        @(negedge clk);
        pmem_resp   = 1'b0;
        dcache_read = 1'b0;

        // ---------------- randomized traffic vs. reference model ----------------
        do_reset();
        m_owner  = 0;
        m_last_d = 1'b0;
        m_wr     = 1'b0;
        m_addr   = '0;
        m_wdata  = '0;
        prev_i   = 1'b0;
        prev_d   = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            // Well-behaved caches: hold until resp, drop the cycle after.
            if (prev_i) icache_read = 1'b0;
            else if (!icache_read) icache_read = ($urandom_range(0, 2) == 0);
            if (prev_d) begin
                dcache_read  = 1'b0;
                dcache_write = 1'b0;
            end else if (!dcache_read && !dcache_write) begin
                op = $urandom_range(0, 5);
                dcache_read  = (op == 1) || (op == 3);
                dcache_write = (op == 2) || (op == 3);
            end
            icache_addr  = 16'($urandom);
            dcache_addr  = 16'($urandom);
            dcache_wdata = rand128();
            pmem_resp    = ($urandom_range(0, 2) == 0);
            pmem_rdata   = rand128();
            #1;
            e_pr = (m_owner == 1) || ((m_owner == 2) && !m_wr);
            e_pw = (m_owner == 2) && m_wr;
            e_ir = (m_owner == 1) && pmem_resp;
            e_dr = (m_owner == 2) && pmem_resp;
            chk("rnd_pmem_read", 128'(pmem_read), 128'(e_pr));
            chk("rnd_pmem_write", 128'(pmem_write), 128'(e_pw));
            chk("rnd_pmem_addr", 128'(pmem_addr), 128'(m_addr));
            chk("rnd_pmem_wdata", pmem_wdata, m_wdata);
            chk("rnd_icache_resp", 128'(icache_resp), 128'(e_ir));
            chk("rnd_dcache_resp", 128'(dcache_resp), 128'(e_dr));
            if (e_ir) chk("rnd_icache_rdata", icache_rdata, pmem_rdata);
            if (e_dr) chk("rnd_dcache_rdata", dcache_rdata, pmem_rdata);
            prev_i = e_ir;
            prev_d = e_dr;
            if (m_owner != 0) begin
                if (pmem_resp) m_owner = 0;
            end else if ((dcache_read || dcache_write) && (!icache_read || !m_last_d)) begin
                m_owner  = 2;
                m_last_d = 1'b1;
                m_addr   = dcache_addr;
                m_wr     = dcache_write;
                if (dcache_write) m_wdata = dcache_wdata;
            end else if (icache_read) begin
                m_owner  = 1;
                m_last_d = 1'b0;
                m_addr   = icache_addr;
                m_wr     = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single physical-memory (L2/pmem) port between the instruction cache and the data cache of the LC-3b pipeline.
- The I-cache is read-only. The D-cache issues line reads and line writebacks.
- Grants one outstanding line transaction at a time and holds the pmem request stable until completion.
- Returns the response only to the granted cache. The other requester stalls, which the hazard/stall logic sees as an unanswered cache request.

Parameters:
ADDR_WIDTH, 16, byte address width of a line request
LINE_WIDTH, 128, cache line width in bits
FIXED_PRIORITY, 0, 1 = D-cache always wins a tie; 0 = round-robin on ties

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-high reset
icache_read  in  1  I-cache line read request, held until icache_resp
icache_addr  in  ADDR_WIDTH  I-cache line address
icache_rdata  out  LINE_WIDTH  line data to I-cache
icache_resp  out  1  one-cycle completion pulse to I-cache
dcache_read  in  1  D-cache line read request, held until dcache_resp
dcache_write  in  1  D-cache line writeback request, held until dcache_resp
dcache_addr  in  ADDR_WIDTH  D-cache line address
dcache_wdata  in  LINE_WIDTH  D-cache writeback line
dcache_rdata  out  LINE_WIDTH  line data to D-cache
dcache_resp  out  1  one-cycle completion pulse to D-cache
pmem_read  out  1  physical memory read strobe
pmem_write  out  1  physical memory write strobe
pmem_addr  out  ADDR_WIDTH  physical memory address
pmem_wdata  out  LINE_WIDTH  physical memory write line
pmem_rdata  in  LINE_WIDTH  physical memory read line
pmem_resp  in  1  physical memory completion, one cycle

Behaviour:
- Clocking and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values:
  - State = IDLE.
  - pmem_read = pmem_write = 0.
  - pmem_addr = pmem_wdata = 0.
  - icache_resp = dcache_resp = 0.
  - last_served = ICACHE, so the D-cache wins the first tie.
- FSM states:
  - IDLE: no grant, pmem strobes low.
  - SERVE_I: I-cache granted.
  - SERVE_D: D-cache granted.
- Request definitions:
  - I request = icache_read.
  - D request = dcache_read | dcache_write.
- Grant, sampled in IDLE at the clock edge:
  - Only one requester active: grant it.
  - Both active with FIXED_PRIORITY=1: grant D.
  - Both active with FIXED_PRIORITY=0: grant the requester not equal to last_served.
  - Update last_served on every grant.
- Registered request latch on grant:
  - pmem_addr is registered from the granted requester's address.
  - For D, the op is latched as write if dcache_write=1, otherwise read. dcache_read & dcache_write both high is treated as write.
  - pmem_wdata is latched from dcache_wdata for D writes; otherwise it holds its prior value.
  - pmem_read/pmem_write assert the cycle after the grant edge and stay constant until pmem_resp.
- Latency: request present in IDLE at cycle N → pmem strobe high in cycle N+1.
- Completion, in SERVE_x when pmem_resp=1 at cycle M:
  - The granted cache's resp = 1 combinationally in cycle M.
  - The granted cache's rdata = pmem_rdata (combinational passthrough). The non-granted rdata is don't-care; drive pmem_rdata to both.
  - The non-granted resp stays 0.
  - Next state = IDLE at M+1, with strobes low in M+1.
  - Earliest next strobe is M+2: one mandatory bubble cycle.
- pmem_resp while in IDLE: ignored, no resp pulse.
- Requester drop mid-transaction: the transaction still completes on pmem, and the resp pulse is still generated. Caches must not depend on abort.
- Requests are level-sensitive. Each cache drops its request in the cycle after its resp, so the IDLE sampling at M+1 does not re-serve a stale request.
- Request address/data changing during a grant: no effect; latched values are used.
- Reset mid-transaction: immediate return to IDLE with strobes low, and any in-flight pmem_resp is dropped. The pmem model is reset together with the arbiter.
- Starvation bound (FIXED_PRIORITY=0): with both caches continuously requesting, grants alternate I/D/I/D.

Test Plan:
- Reset then icache_read=1, addr 0x1230 → pmem_read=1 and pmem_addr=0x1230 one cycle later. pmem_resp with rdata 0xA5..A5 → icache_resp=1 same cycle with that data, dcache_resp=0, strobes low the next cycle.
- D writeback addr 0x4000, wdata 0xDEAD_BEEF_... → pmem_write=1, pmem_read=0, pmem_wdata equals the written line. Changing dcache_wdata mid-grant does not alter pmem_wdata.
- Both caches request at once after reset (FIXED_PRIORITY=0) → D is granted first, then I after the bubble. Continuous requests for 6 transactions → grant order D,I,D,I,D,I.
- FIXED_PRIORITY=1 with both caches requesting continuously → only D is served. Dropping D → I is served on the next IDLE sample.
- Assert reset while in SERVE_D with a pmem_resp arriving the next cycle → strobes 0 immediately, no dcache_resp pulse, state IDLE.
- Spurious pmem_resp in IDLE → no resp pulse. dcache_read & dcache_write both high → pmem_write=1 only.
